// File: rtl/full_adder_nbits_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_nbits_pkg
// Purpose : Shared constants and bit-level helper functions for the
//           calculator adder core. It holds the legal operand-width range
//           and the two Boolean equations of a full-adder cell, so the cell
//           and any future adder variant use one definition.
// Contents: FA_WIDTH_MIN / FA_WIDTH_MAX / FA_WIDTH_DEFAULT
//           fa_sum()   - sum bit of a full adder
//           fa_carry() - carry-out bit of a full adder (majority)
// -----------------------------------------------------------------------------
package full_adder_nbits_pkg;

    localparam int FA_WIDTH_MIN     = 1;
    localparam int FA_WIDTH_MAX     = 64;
    localparam int FA_WIDTH_DEFAULT = 8;

    // Sum bit: odd parity of the three inputs.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry bit: majority of the three inputs.
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
// Purpose : Purely combinational 1-bit full-adder cell, the building block of
//           the ripple-carry chain in full_adder_nbits.
// Ports   : a_i, b_i  - operand bits
//           cin_i     - carry in from the previous cell
//           s_o       - sum bit
//           cout_o    - carry out to the next cell
// -----------------------------------------------------------------------------
module full_adder_1bit
    import full_adder_nbits_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic w_s;
    logic w_cout;

    assign w_s    = fa_sum(a_i, b_i, cin_i);
    assign w_cout = fa_carry(a_i, b_i, cin_i);

    assign s_o    = w_s;
    assign cout_o = w_cout;

endmodule

// File: rtl/full_adder_nbits.sv
// -----------------------------------------------------------------------------
// full_adder_nbits
// Purpose : Unsigned width-bit ripple-carry adder with registered sum and
//           carry-out; arithmetic core of the calculator datapath.
//           {cout_o, s_o} is the exact (width+1)-bit sum of a_i and b_i,
//           one clock after the operands are sampled. Overflow wraps.
// Params  : width   - operand/sum width, legal range 1..64
// Ports   : clk_i   - system clock, rising edge
//           rst_n_i - asynchronous active-low reset, clears outputs
//           a_i     - operand A (unsigned)
//           b_i     - operand B (unsigned)
//           s_o     - registered sum, (a_i + b_i) mod 2^width
//           cout_o  - registered carry-out, bit width of a_i + b_i
// -----------------------------------------------------------------------------
module full_adder_nbits
    import full_adder_nbits_pkg::*;
#(
    parameter int width = FA_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] s_o,
    output logic             cout_o
);

    // Carry vector: w_c[k] is the carry into cell k, w_c[width] the carry-out.
    logic [width:0]   w_c;
    logic [width-1:0] w_s;

    logic [width-1:0] r_s;
    logic             r_cout;

    // No carry-in port: the chain always starts from zero.
    assign w_c[0] = 1'b0;

    // The whole chain is a single combinational ripple with no pipeline cuts.
    for (genvar k = 0; k < width; k++) begin : g_cell
        full_adder_1bit u_cell (
            .a_i    (a_i[k]),
            .b_i    (b_i[k]),
            .cin_i  (w_c[k]),
            .s_o    (w_s[k]),
            .cout_o (w_c[k+1])
        );
    end

    // Output register: reloads every cycle, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s    <= {width{1'b0}};
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_c[width];
        end
    end

    assign s_o    = r_s;
    assign cout_o = r_cout;

endmodule

// File: tb/tb_full_adder_nbits.sv
// Self-checking bench: four adder instances (width 8, 1, 4, 32) share one
// clock and reset; each is fed the low bits of the same 32-bit operands.
module tb_full_adder_nbits;

    typedef struct packed {
        logic [8:0]  e8;
        logic [1:0]  e1;
        logic [4:0]  e4;
        logic [32:0] e32;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a8,  b8,  s8;
    logic [0:0]  a1,  b1,  s1;
    logic [3:0]  a4,  b4,  s4;
    logic [31:0] a32, b32, s32;
    logic        c8, c1, c4, c32;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    full_adder_nbits #(.width(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a8), .b_i(b8), .s_o(s8), .cout_o(c8));
    full_adder_nbits #(.width(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a1), .b_i(b1), .s_o(s1), .cout_o(c1));
    full_adder_nbits #(.width(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a4), .b_i(b4), .s_o(s4), .cout_o(c4));
    full_adder_nbits #(.width(32)) u_dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a32), .b_i(b32), .s_o(s32), .cout_o(c32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare all four instances against one expected record.
    task automatic check_all(input string tag, input exp_t e);
        checks++;
        assert ({c8, s8} === e.e8) else begin
            failures++;
            $error("FAIL %s w8: observed=%h expected=%h", tag, {c8, s8}, e.e8);
        end
        checks++;
        assert ({c1, s1} === e.e1) else begin
            failures++;
            $error("FAIL %s w1: observed=%h expected=%h", tag, {c1, s1}, e.e1);
        end
        checks++;
        assert ({c4, s4} === e.e4) else begin
            failures++;
            $error("FAIL %s w4: observed=%h expected=%h", tag, {c4, s4}, e.e4);
        end
        checks++;
        assert ({c32, s32} === e.e32) else begin
            failures++;
            $error("FAIL %s w32: observed=%h expected=%h", tag, {c32, s32}, e.e32);
        end
    endtask

    // Drive operands (all widths take the low bits) without touching the queue.
    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        a32 = a;       b32 = b;
        a8  = a[7:0];  b8  = b[7:0];
        a4  = a[3:0];  b4  = b[3:0];
        a1  = a[0:0];  b1  = b[0:0];
    endtask

    // One cycle: at the falling edge check the result due from the previous
    // operands, then drive new operands and push their expected sums.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) check_all(tag, exp_q.pop_front());
        set_ops(a, b);
        e.e8  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        e.e1  = {1'b0, a[0]}   + {1'b0, b[0]};
        e.e4  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        e.e32 = {1'b0, a}      + {1'b0, b};
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t zero;
        zero = '0;
        rst_n = 1'b1;
        set_ops(32'hFFFF_FFFF, 32'h0000_0001);
        #1 rst_n = 1'b0;

        // Reset held with a carry-producing input and the clock running.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all("reset_hold", zero);
        end

        // Release between edges; first result follows the next rising edge.
        rst_n = 1'b1;
        step("basic",      32'd23,        32'd42);
        step("ovf_ff_01",  32'hFFFF_FFFF, 32'h0000_0001);
        step("ovf_ff_ff",  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("prop_80_80", 32'h8000_0080, 32'h8000_0080);
        step("prop_7f_01", 32'h7FFF_FF7F, 32'h0000_0001);
        step("zero",       32'd0,         32'd0);
        step("w4_edge",    32'h0000_000F, 32'h0000_0001);
        step("one_one",    32'd1,         32'd1);

        // Random back-to-back operands.
        for (int i = 0; i < 1000; i++)
            step("random", $urandom, $urandom);
        step("zero_end", 32'd0, 32'd0);
        step("ovf_load", 32'hFFFF_FFFF, 32'h0000_0001);

        // Mid-operation reset between edges: outputs (carry set) clear at once.
        @(posedge clk);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1 check_all("reset_async", zero);
        @(negedge clk);
        check_all("reset_mid_hold", zero);
        @(negedge clk);
        check_all("reset_mid_edge", zero);

        // Recovery: normal results resume right after release.
        rst_n = 1'b1;
        step("post_reset",   32'd200,       32'd100);
        step("post_reset2",  32'h1234_5678, 32'h8765_4321);
        step("post_reset3",  32'd0,         32'd0);
        @(negedge clk);
        if (exp_q.size() > 0) check_all("flush", exp_q.pop_front());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
